sprite_fetch: RTL and testbench
===============================

Name: sprite_fetch

Overview:
- Read-side client of the single-clock block RAM that holds sprite images (12-bit RGB, synchronous read, 1-cycle registered q).
- From the VGA pixel_row/pixel_column stream, it decides whether the current pixel falls inside the sprite window and generates the RAM read address.
- It aligns the RAM's read latency and outputs the sprite colour plus an opaque-hit flag to the colour mixer.
- It also owns the sprite position (updated only at frame boundary through a valid/ready handshake) and the animation frame index.

Parameters:
- DATA_WIDTH, 12, RAM word / colour width.
- ADDR_WIDTH, 15, RAM address width.
- SPRITE_W, 64, sprite width in pixels; power of two.
- SPRITE_H, 64, sprite height in pixels.
- NUM_FRAMES, 4, animation frames stored back to back; NUM_FRAMES*SPRITE_W*SPRITE_H <= 2**ADDR_WIDTH.
- FRAME_TICKS, 8, vsync ticks per animation step (>=1).
- TRANSPARENT, 12'hFFF, colour value treated as see-through.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- video_on  in  1  high during the active display region.
- pixel_row  in  12  current VGA row.
- pixel_column  in  12  current VGA column.
- vsync_tick  in  1  one-cycle pulse, once per frame, outside the active region.
- pos_x  in  12  requested sprite left edge.
- pos_y  in  12  requested sprite top edge.
- pos_valid  in  1  position request valid.
- pos_ready  out  1  block can accept a position.
- anim_en  in  1  enables animation advance.
- read_addr  out  ADDR_WIDTH  RAM read address, registered.
- ram_q  in  DATA_WIDTH  RAM read data.
- pixel_color  out  DATA_WIDTH  sprite colour, 0 when not valid.
- pixel_valid  out  1  opaque sprite pixel present.
- frame_idx  out  clog2(NUM_FRAMES)  current animation frame.

Behaviour:
- Reset, synchronous on clk:
  - cur_x, cur_y, shadow_x, shadow_y <= 0; pending <= 0; pos_ready <= 1.
  - tick_cnt <= 0; frame_idx <= 0.
  - All pipeline registers, read_addr, pixel_color and pixel_valid <= 0.
  - Reset mid-frame discards any pending position and any in-flight pixels.
- Position handshake:
  - A transfer occurs when pos_valid && pos_ready. It loads shadow_x/y, sets pending, and drops pos_ready the following cycle.
  - On vsync_tick with pending=1: cur_x/y <= shadow_x/y, pending <= 0, pos_ready <= 1.
  - pos_ready is low while pending, so a transfer and an apply can never hit the same shadow value.
  - A transfer in the same cycle as vsync_tick (pending=0) is applied at the next vsync_tick, not the current one.
  - pos_valid held high while pos_ready=0 has no effect.
- Animation:
  - On vsync_tick with anim_en=1, tick_cnt increments.
  - When tick_cnt == FRAME_TICKS-1, tick_cnt <= 0 and frame_idx <= (frame_idx+1) mod NUM_FRAMES, wrapping NUM_FRAMES-1 -> 0.
  - With anim_en=0, both tick_cnt and frame_idx hold.
- Hit test, combinational, stage 0:
  - hit0 = video_on && col >= cur_x && col < cur_x+SPRITE_W && row >= cur_y && row < cur_y+SPRITE_H.
  - Sums are computed at 13 bits, so a window near 4095 does not wrap.
  - dx = col-cur_x, dy = row-cur_y.
- Pipeline, latency 3 clocks from coordinates to output:
  - Edge 1: read_addr <= hit0 ? frame_idx*SPRITE_W*SPRITE_H + dy*SPRITE_W + dx (truncated to ADDR_WIDTH) : 0. hit1 <= hit0.
  - Edge 2: the RAM registers ram_q. hit2 <= hit1.
  - Edge 3: pixel_valid <= hit2 && (ram_q != TRANSPARENT). pixel_color <= that ? ram_q : 0.
- The pipeline runs every cycle with no stall. The caller delays its own row/column by 3 to align.
- A position or frame change takes effect only for pixels entering stage 0 after the update edge. Pixels already in flight complete with their old address.

Test Plan:
- Reset, then 1 cycle idle -> pos_ready=1, frame_idx=0, read_addr=0, pixel_valid=0, pixel_color=0.
- Pos handshake: pos_x=100, pos_y=50, pos_valid for 1 cycle -> pos_ready=0.
  - Column 100, row 50 before vsync_tick -> no hit.
  - After vsync_tick -> pos_ready=1; column 100, row 50 -> read_addr=0 one cycle later.
  - Column 163, row 51 -> read_addr=127.
  - Column 164 -> pixel_valid=0.
- Latency: RAM model returns 12'h0F0 at addr 5; drive column 105, row 50 at cycle t -> pixel_valid=1 and pixel_color=12'h0F0 at t+3.
  - Same with RAM data 12'hFFF -> pixel_valid=0, pixel_color=0.
- Animation: anim_en=1, FRAME_TICKS=8, 8 vsync_ticks -> frame_idx=1.
  - Pixel at sprite origin -> read_addr=4096.
  - 32 ticks total -> frame_idx wraps to 0.
  - anim_en=0 for 10 ticks -> frame_idx unchanged.
- Edge window: pos_x=4090 -> column 4095 hits with dx=5; columns 0..57 produce no hit (no wrap).
  - video_on=0 with in-window coordinates -> no hit.
- Simultaneous/reset:
  - pos_valid on the same cycle as vsync_tick -> position applied only at the following vsync_tick.
  - Assert reset while pending=1 -> pending cleared, cur_x/y=0, pos_ready=1 the next cycle.

Source files
------------

// File: rtl/sprite_fetch_if.sv
// Position request channel for the sprite fetch block.
interface sprite_fetch_if;
    logic [11:0] pos_x;
    logic [11:0] pos_y;
    logic        pos_valid;
    logic        pos_ready;

    modport master (output pos_x, output pos_y, output pos_valid, input pos_ready);
    modport slave  (input pos_x, input pos_y, input pos_valid, output pos_ready);
endinterface

// File: rtl/sprite_fetch.sv
// Sprite fetch: window hit test, sprite RAM addressing and latency-aligned colour output.
// Position updates are double-buffered and applied at vsync; animation advances every
// FRAME_TICKS vsyncs while anim_en is high.
module sprite_fetch #(
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned ADDR_WIDTH  = 15,
    parameter int unsigned SPRITE_W    = 64,
    parameter int unsigned SPRITE_H    = 64,
    parameter int unsigned NUM_FRAMES  = 4,
    parameter int unsigned FRAME_TICKS = 8,
    parameter logic [DATA_WIDTH-1:0] TRANSPARENT = 12'hFFF,
    localparam int unsigned FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  video_on,
    input  logic [11:0]           pixel_row,
    input  logic [11:0]           pixel_column,
    input  logic                  vsync_tick,
    sprite_fetch_if.slave         pos,
    input  logic                  anim_en,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] pixel_color,
    output logic                  pixel_valid,
    output logic [FW-1:0]         frame_idx
);
    localparam int unsigned TW          = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int unsigned FRAME_WORDS = SPRITE_W * SPRITE_H;

    logic [11:0]           cur_x_q, cur_y_q, shadow_x_q, shadow_y_q;
    logic                  pending_q, pos_ready_q;
    logic [TW-1:0]         tick_cnt_q;
    logic                  hit1_q, hit2_q;

    logic [12:0]           col_w, row_w, x_lo, y_lo, x_hi, y_hi;
    logic [11:0]           dx, dy;
    logic                  hit0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic                  opaque;

    assign pos.pos_ready = pos_ready_q;

    // Stage 0: window test at 13 bits so a window near the right/bottom edge cannot wrap
    always_comb begin
        col_w  = {1'b0, pixel_column};
        row_w  = {1'b0, pixel_row};
        x_lo   = {1'b0, cur_x_q};
        y_lo   = {1'b0, cur_y_q};
        x_hi   = x_lo + 13'(SPRITE_W);
        y_hi   = y_lo + 13'(SPRITE_H);
        dx     = pixel_column - cur_x_q;
        dy     = pixel_row - cur_y_q;
        hit0   = video_on && (col_w >= x_lo) && (col_w < x_hi) &&
                 (row_w >= y_lo) && (row_w < y_hi);
        addr0  = ADDR_WIDTH'(32'(frame_idx) * FRAME_WORDS + 32'(dy) * SPRITE_W + 32'(dx));
        opaque = hit2_q && (ram_q != TRANSPARENT);
    end

    // Position handshake; pos_ready is low while pending, so load and apply never overlap
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            shadow_x_q  <= '0;
            shadow_y_q  <= '0;
            pending_q   <= 1'b0;
            pos_ready_q <= 1'b1;
        end else if (pos.pos_valid && pos_ready_q) begin
            shadow_x_q  <= pos.pos_x;
            shadow_y_q  <= pos.pos_y;
            pending_q   <= 1'b1;
            pos_ready_q <= 1'b0;
        end else if (vsync_tick && pending_q) begin
            cur_x_q     <= shadow_x_q;
            cur_y_q     <= shadow_y_q;
            pending_q   <= 1'b0;
            pos_ready_q <= 1'b1;
        end
    end

    // Animation: count vsyncs, step the frame index every FRAME_TICKS of them
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
            frame_idx  <= '0;
        end else if (vsync_tick && anim_en) begin
            if (tick_cnt_q == TW'(FRAME_TICKS - 1)) begin
                tick_cnt_q <= '0;
                frame_idx  <= (frame_idx == FW'(NUM_FRAMES - 1)) ? '0 : frame_idx + FW'(1);
            end else begin
                tick_cnt_q <= tick_cnt_q + TW'(1);
            end
        end
    end

    // Fixed 3-cycle pipeline: address, RAM read, colour qualify
    always_ff @(posedge clk) begin
        if (reset) begin
            read_addr   <= '0;
            hit1_q      <= 1'b0;
            hit2_q      <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_color <= '0;
        end else begin
            read_addr   <= hit0 ? addr0 : '0;
            hit1_q      <= hit0;
            hit2_q      <= hit1_q;
            pixel_valid <= opaque;
            pixel_color <= opaque ? ram_q : '0;
        end
    end
endmodule

// File: tb/tb_sprite_fetch.sv
// Scoreboard bench for sprite_fetch: stimulus queues expected address/colour with a due
// cycle; a negedge monitor pops and compares when each entry comes due.
module tb_sprite_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        video_on;
    logic [11:0] pixel_row, pixel_column;
    logic        vsync_tick;
    logic        anim_en;
    logic [14:0] read_addr;
    logic [11:0] ram_q;
    logic [11:0] pixel_color;
    logic        pixel_valid;
    logic [1:0]  frame_idx;

    sprite_fetch_if pif ();

    sprite_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .video_on     (video_on),
        .pixel_row    (pixel_row),
        .pixel_column (pixel_column),
        .vsync_tick   (vsync_tick),
        .pos          (pif),
        .anim_en      (anim_en),
        .read_addr    (read_addr),
        .ram_q        (ram_q),
        .pixel_color  (pixel_color),
        .pixel_valid  (pixel_valid),
        .frame_idx    (frame_idx)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous read, registered q
    logic [11:0] mem [0:32767];
    always @(posedge clk) ram_q <= mem[read_addr];

    function automatic logic [11:0] ram_init(input int a);
        return 12'((a * 7 + 3) & 32'h7FF);
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; logic [14:0] addr; } addr_exp_t;
    typedef struct { int due; logic v; logic [11:0] c; } out_exp_t;
    addr_exp_t addr_q[$];
    out_exp_t  out_q[$];
    addr_exp_t ea;
    out_exp_t  eo;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor: compare every scoreboard entry that has come due
    always @(negedge clk) begin
        while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
            ea = addr_q.pop_front();
            n_checks++;
            if (ea.due != cyc || read_addr !== ea.addr) begin
                n_fail++;
                $display("FAIL read_addr due %0d at %0d: got %0d expected %0d",
                         ea.due, cyc, read_addr, ea.addr);
            end
        end
        while (out_q.size() > 0 && out_q[0].due <= cyc) begin
            eo = out_q.pop_front();
            n_checks++;
            if (eo.due != cyc || pixel_valid !== eo.v || pixel_color !== eo.c) begin
                n_fail++;
                $display("FAIL pixel_out due %0d at %0d: got v=%0b c=%03h expected v=%0b c=%03h",
                         eo.due, cyc, pixel_valid, pixel_color, eo.v, eo.c);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance past the next rising edge and return single-cycle inputs to idle
    task automatic step();
        @(posedge clk);
        #2;
        video_on      = 1'b0;
        vsync_tick    = 1'b0;
        pif.pos_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pix(input logic [11:0] c, input logic [11:0] r, input logic von,
                       input logic [14:0] exp_addr, input logic exp_v, input logic [11:0] exp_c);
        addr_exp_t a;
        out_exp_t  o;
        step();
        video_on     = von;
        pixel_column = c;
        pixel_row    = r;
        a.due  = cyc + 1;
        a.addr = exp_addr;
        o.due  = cyc + 3;
        o.v    = exp_v;
        o.c    = exp_c;
        addr_q.push_back(a);
        out_q.push_back(o);
    endtask

    task automatic hit(input logic [11:0] c, input logic [11:0] r, input int a);
        pix(c, r, 1'b1, 15'(a), 1'b1, ram_init(a));
    endtask

    task automatic miss(input logic [11:0] c, input logic [11:0] r);
        pix(c, r, 1'b1, 15'd0, 1'b0, 12'h000);
    endtask

    task automatic send_pos(input logic [11:0] x, input logic [11:0] y, input logic with_vs);
        step();
        pif.pos_x     = x;
        pif.pos_y     = y;
        pif.pos_valid = 1'b1;
        vsync_tick    = with_vs;
    endtask

    task automatic vsync();
        step();
        vsync_tick = 1'b1;
    endtask

    task automatic vsyncs(input int n);
        repeat (n) vsync();
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = ram_init(i);
        reset = 1'b1; video_on = 1'b0; vsync_tick = 1'b0; anim_en = 1'b0;
        pixel_row = '0; pixel_column = '0;
        pif.pos_x = '0; pif.pos_y = '0; pif.pos_valid = 1'b0;
        idle(3);
        reset = 1'b0;
        step();
        chk("reset_pos_ready", 32'(pif.pos_ready), 1);
        chk("reset_frame_idx", 32'(frame_idx), 0);
        chk("reset_read_addr", 32'(read_addr), 0);
        chk("reset_pixel_valid", 32'(pixel_valid), 0);
        chk("reset_pixel_color", 32'(pixel_color), 0);

        // Position handshake, plus a request while not ready that must be ignored
        send_pos(12'd100, 12'd50, 1'b0);
        step();
        chk("hs_ready_low", 32'(pif.pos_ready), 0);
        send_pos(12'd500, 12'd500, 1'b0);
        miss(12'd100, 12'd50);
        vsync();
        step();
        chk("hs_ready_high", 32'(pif.pos_ready), 1);
        hit(12'd100, 12'd50, 0);
        hit(12'd163, 12'd51, 127);
        miss(12'd164, 12'd51);
        miss(12'd99, 12'd50);
        miss(12'd100, 12'd49);
        hit(12'd100, 12'd113, 4032);
        miss(12'd100, 12'd114);
        idle(4);

        // Latency and transparency
        mem[5] = 12'h0F0;
        pix(12'd105, 12'd50, 1'b1, 15'd5, 1'b1, 12'h0F0);
        idle(4);
        mem[5] = 12'hFFF;
        pix(12'd105, 12'd50, 1'b1, 15'd5, 1'b0, 12'h000);
        idle(4);

        // Animation
        anim_en = 1'b1;
        vsyncs(8);
        chk("anim_frame1", 32'(frame_idx), 1);
        hit(12'd100, 12'd50, 4096);
        vsyncs(8);
        chk("anim_frame2", 32'(frame_idx), 2);
        vsyncs(8);
        chk("anim_frame3", 32'(frame_idx), 3);
        vsyncs(8);
        chk("anim_wrap", 32'(frame_idx), 0);
        vsyncs(8);
        chk("anim_frame1b", 32'(frame_idx), 1);
        vsyncs(4);
        anim_en = 1'b0;
        vsyncs(10);
        chk("anim_hold", 32'(frame_idx), 1);
        anim_en = 1'b1;
        vsyncs(3);
        chk("anim_tick_held", 32'(frame_idx), 1);
        vsyncs(1);
        chk("anim_frame2b", 32'(frame_idx), 2);
        anim_en = 1'b0;

        // Window at the right edge must not wrap into low columns
        send_pos(12'd4090, 12'd50, 1'b0);
        vsync();
        step();
        hit(12'd4095, 12'd50, 8192 + 5);
        hit(12'd4090, 12'd113, 8192 + 63 * 64);
        for (int c = 0; c <= 57; c++) miss(12'(c), 12'd50);
        pix(12'd4095, 12'd50, 1'b0, 15'd0, 1'b0, 12'h000);
        idle(4);

        // Transfer coinciding with vsync applies only at the following vsync
        send_pos(12'd200, 12'd60, 1'b1);
        step();
        chk("sim_ready_low", 32'(pif.pos_ready), 0);
        miss(12'd200, 12'd60);
        vsync();
        step();
        chk("sim_ready_high", 32'(pif.pos_ready), 1);
        hit(12'd200, 12'd60, 8192);
        idle(4);

        // Reset while a position is pending
        send_pos(12'd300, 12'd70, 1'b0);
        step();
        chk("rst_pending_ready_low", 32'(pif.pos_ready), 0);
        idle(4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_ready", 32'(pif.pos_ready), 1);
        chk("rst_frame_idx", 32'(frame_idx), 0);
        chk("rst_pixel_valid", 32'(pixel_valid), 0);
        hit(12'd0, 12'd0, 0);
        miss(12'd300, 12'd70);
        vsync();
        miss(12'd300, 12'd70);
        hit(12'd63, 12'd63, 4095);
        idle(6);

        chk("scoreboard_drained", 32'(addr_q.size() + out_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
